// File: rtl/aes_wb_sequencer.sv
// Wishbone slave that holds AES key/block/config/result registers and sequences
// the core's key-expansion (init) and block (next) commands, raising an irq on completion.
module aes_wb_sequencer #(
  parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
  parameter bit          AUTO_NEXT = 1'b1
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic         wbs_cyc_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic         wbs_ack_o,
  output logic [31:0]  wbs_dat_o,
  output logic         aes_init_o,
  output logic         aes_next_o,
  output logic         aes_encdec_o,
  output logic         aes_keylen_o,
  output logic [255:0] aes_key_o,
  output logic [127:0] aes_block_o,
  input  logic         aes_ready_i,
  input  logic [127:0] aes_result_i,
  input  logic         aes_result_valid_i,
  output logic         irq_o,
  output logic [2:0]   dbg_state_o
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_KEY_START = 3'd1;
  localparam logic [2:0] ST_KEY_WAIT  = 3'd2;
  localparam logic [2:0] ST_BLK_START = 3'd3;
  localparam logic [2:0] ST_BLK_WAIT  = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  logic [2:0]   state_q, state_d;
  logic         ack_q, ack_d;
  logic [31:0]  rdata_q, rdata_d;
  logic [255:0] key_q, key_d;
  logic [127:0] block_q, block_d;
  logic [127:0] result_q, result_d;
  logic         encdec_q, encdec_d;
  logic         keylen_q, keylen_d;
  logic         irq_en_q, irq_en_d;
  logic         done_q, done_d;
  logic         key_valid_q, key_valid_d;
  logic         err_q, err_d;
  logic         irq_q, irq_d;
  logic         seen_low_q, seen_low_d;

  logic         hit, accept, wr, rd, busy, complete;
  logic [5:0]   wa;
  logic [31:0]  cfg_new;
  logic         unused_bits;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Wishbone: a strobe is taken only while ack is low, so ack lasts exactly one
  // cycle and back-to-back strobes are served every other cycle.
  assign hit    = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign accept = wbs_cyc_i && wbs_stb_i && !ack_q && hit;
  assign wr     = accept && wbs_we_i;
  assign rd     = accept && !wbs_we_i;
  assign wa     = wbs_adr_i[7:2];
  assign busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign cfg_new = byte_merge({29'd0, irq_en_q, keylen_q, encdec_q}, wbs_dat_i, wbs_sel_i);
  assign unused_bits = ^{wbs_adr_i[1:0], cfg_new[31:3]};

  always_comb begin
    state_d     = state_q;
    ack_d       = accept;
    rdata_d     = 32'd0;
    key_d       = key_q;
    block_d     = block_q;
    result_d    = result_q;
    encdec_d    = encdec_q;
    keylen_d    = keylen_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    key_valid_d = key_valid_q;
    err_d       = err_q;
    irq_d       = irq_q;
    seen_low_d  = seen_low_q;
    complete    = 1'b0;

    // The core must be seen not-ready before its ready counts as completion.
    case (state_q)
      ST_KEY_START: begin
        seen_low_d = 1'b0;
        state_d    = ST_KEY_WAIT;
      end
      ST_KEY_WAIT: begin
        if (!aes_ready_i) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          key_valid_d = 1'b1;
          if (AUTO_NEXT) begin
            state_d = ST_BLK_START;
          end else begin
            state_d  = ST_DONE;
            complete = 1'b1;
          end
        end
      end
      ST_BLK_START: begin
        seen_low_d = 1'b0;
        state_d    = ST_BLK_WAIT;
      end
      ST_BLK_WAIT: begin
        if (!aes_ready_i) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q && aes_result_valid_i) begin
          result_d = aes_result_i;
          state_d  = ST_DONE;
          complete = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (complete) begin
      done_d = 1'b1;
      irq_d  = irq_en_q;
    end

    if (wr) begin
      if (wa == 6'd0) begin
        if (wbs_dat_i[2] && !complete) begin
          irq_d  = 1'b0;
          done_d = 1'b0;
        end
        if (wbs_dat_i[0]) begin
          if (busy || !(wbs_dat_i[1] || key_valid_q)) begin
            err_d = 1'b1;
          end else begin
            state_d = wbs_dat_i[1] ? ST_KEY_START : ST_BLK_START;
            err_d   = 1'b0;
            done_d  = 1'b0;
            irq_d   = 1'b0;
          end
        end
      end else if (wa == 6'd2 || (wa >= 6'd4 && wa <= 6'd15)) begin
        if (busy) begin
          err_d = 1'b1;
        end else if (wa == 6'd2) begin
          encdec_d = cfg_new[0];
          keylen_d = cfg_new[1];
          irq_en_d = cfg_new[2];
          if (cfg_new[1] != keylen_q) key_valid_d = 1'b0;
        end else if (wa <= 6'd11) begin
          key_valid_d = 1'b0;
          for (int i = 0; i < 8; i++) begin
            if (wa == 6'(4 + i))
              key_d[255-32*i -: 32] = byte_merge(key_q[255-32*i -: 32], wbs_dat_i, wbs_sel_i);
          end
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (wa == 6'(12 + i))
              block_d[127-32*i -: 32] = byte_merge(block_q[127-32*i -: 32], wbs_dat_i, wbs_sel_i);
          end
        end
      end
    end

    if (rd) begin
      if (wa == 6'd1) rdata_d = {28'd0, err_q, key_valid_q, done_q, busy};
      if (wa == 6'd2) rdata_d = {29'd0, irq_en_q, keylen_q, encdec_q};
      for (int i = 0; i < 8; i++) begin
        if (wa == 6'(4 + i)) rdata_d = key_q[255-32*i -: 32];
      end
      for (int i = 0; i < 4; i++) begin
        if (wa == 6'(12 + i)) rdata_d = block_q[127-32*i -: 32];
        if (wa == 6'(16 + i)) rdata_d = result_q[127-32*i -: 32];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      rdata_q     <= 32'd0;
      key_q       <= 256'd0;
      block_q     <= 128'd0;
      result_q    <= 128'd0;
      encdec_q    <= 1'b0;
      keylen_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
      seen_low_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      key_q       <= key_d;
      block_q     <= block_d;
      result_q    <= result_d;
      encdec_q    <= encdec_d;
      keylen_q    <= keylen_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
      seen_low_q  <= seen_low_d;
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = rdata_q;
  assign aes_init_o   = (state_q == ST_KEY_START);
  assign aes_next_o   = (state_q == ST_BLK_START);
  assign aes_encdec_o = encdec_q;
  assign aes_keylen_o = keylen_q;
  assign aes_key_o    = key_q;
  assign aes_block_o  = block_q;
  assign irq_o        = irq_q;
  assign dbg_state_o  = state_q;

endmodule
